// File: rtl/i2c_slave_fsm.sv
// ---------------------------------------------------------------------------
// i2c_slave_fsm
//   I2C target state machine. It oversamples scl/sda on the system clock and
//   detects START and STOP. It matches a 7-bit address and ACKs it, then
//   either receives write bytes or serves read bytes. The slave never
//   stretches scl.
//
// Ports
//   clk          system clock, everything on posedge
//   rst_n        asynchronous active-low reset
//   scl          bus clock input
//   sda          open-drain bus data; driven only 0 or z
//   tx_data      byte returned on a read, captured when tx_load pulses
//   tx_load      1-cycle pulse when tx_data is captured
//   rx_data      last received write byte
//   rx_valid     1-cycle pulse when rx_data updates
//   addr_match   1-cycle pulse when the own address is recognised
//   busy         high from START until STOP
//   state_slave  current FSM state encoding
// ---------------------------------------------------------------------------
module i2c_slave_fsm #(
  parameter int                  ADDR_LEN    = 7,
  parameter int                  DATA_LEN    = 8,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR  = 7'b1010110,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  inout  wire                 sda,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_load,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                addr_match,
  output logic                busy,
  output logic [3:0]          state_slave
);

  // The receive shifter only needs to hold the bits that precede the sampled
  // one: the full address (R_W is not shifted in) or DATA_LEN-1 data bits.
  localparam int SHW  = (ADDR_LEN > DATA_LEN - 1) ? ADDR_LEN : DATA_LEN - 1;
  localparam int CNTW = $clog2(((ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN) + 2);

  localparam logic [CNTW-1:0] CNT_ADDR      = CNTW'(ADDR_LEN);
  localparam logic [CNTW-1:0] CNT_ADDR_DONE = CNTW'(ADDR_LEN + 1);
  localparam logic [CNTW-1:0] CNT_DATA      = CNTW'(DATA_LEN);
  localparam logic [CNTW-1:0] CNT_DATA_LAST = CNTW'(DATA_LEN - 1);
  localparam logic [CNTW-1:0] CNT_ONE       = CNTW'(1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_RX_DATA   = 4'd3,
    S_RX_ACK    = 4'd4,
    S_TX_DATA   = 4'd5,
    S_TX_ACK    = 4'd6,
    S_WAIT_STOP = 4'd7
  } state_t;

  // Synchronisers preset to 1 so a reset never fabricates a bus edge
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t                 state, state_next;
  logic [CNTW-1:0]        cnt, cnt_next;
  logic [SHW-1:0]         shift, shift_next;
  logic [DATA_LEN-1:0]    tx_shift, tx_shift_next;
  logic                   rw, rw_next;
  logic                   drive_low, drive_next;
  logic [DATA_LEN-1:0]    rx_data_next;
  logic                   rx_valid_next, tx_load_next, addr_match_next, busy_next;

  assign sda         = drive_low ? 1'b0 : 1'bz;
  assign state_slave = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // While we pull sda low ourselves, any sda edge is our own doing
  assign start_det = scl_s & sda_d & ~sda_s & ~drive_low;
  assign stop_det  = scl_s & ~sda_d & sda_s & ~drive_low;

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    shift_next      = shift;
    tx_shift_next   = tx_shift;
    rw_next         = rw;
    drive_next      = drive_low;
    rx_data_next    = rx_data;
    rx_valid_next   = 1'b0;
    tx_load_next    = 1'b0;
    addr_match_next = 1'b0;
    busy_next       = busy;

    if (start_det) begin
      state_next = S_ADDR;
      cnt_next   = '0;
      drive_next = 1'b0;
      busy_next  = 1'b1;
    end else if (stop_det) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      drive_next = 1'b0;
      busy_next  = 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise && cnt <= CNT_ADDR) begin
            cnt_next = cnt + 1'b1;
            if (cnt == CNT_ADDR) begin
              rw_next = sda_s;
              if (shift[ADDR_LEN-1:0] == SLAVE_ADDR) addr_match_next = 1'b1;
              else                                   state_next      = S_WAIT_STOP;
            end else begin
              shift_next = {shift[SHW-2:0], sda_s};
            end
          end else if (scl_fall && cnt == CNT_ADDR_DONE) begin
            state_next = S_ADDR_ACK;
            drive_next = 1'b1;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_next = '0;
            if (!rw) begin
              drive_next = 1'b0;
              state_next = S_RX_DATA;
            end else begin
              // Capture the byte and present its MSB on the same falling edge
              tx_shift_next = {tx_data[DATA_LEN-2:0], 1'b0};
              tx_load_next  = 1'b1;
              drive_next    = ~tx_data[DATA_LEN-1];
              cnt_next      = CNT_ONE;
              state_next    = S_TX_DATA;
            end
          end
        end
        S_RX_DATA: begin
          if (scl_rise && cnt < CNT_DATA) begin
            cnt_next   = cnt + 1'b1;
            shift_next = {shift[SHW-2:0], sda_s};
            if (cnt == CNT_DATA_LAST) begin
              rx_data_next  = {shift[DATA_LEN-2:0], sda_s};
              rx_valid_next = 1'b1;
            end
          end else if (scl_fall && cnt == CNT_DATA) begin
            state_next = S_RX_ACK;
            drive_next = 1'b1;
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            drive_next = 1'b0;
            cnt_next   = '0;
            state_next = S_RX_DATA;
          end
        end
        S_TX_DATA: begin
          // cnt counts bits already presented on the bus
          if (scl_fall) begin
            if (cnt < CNT_DATA) begin
              drive_next    = ~tx_shift[DATA_LEN-1];
              tx_shift_next = {tx_shift[DATA_LEN-2:0], 1'b0};
              cnt_next      = cnt + 1'b1;
            end else begin
              drive_next = 1'b0;
              cnt_next   = '0;
              state_next = S_TX_ACK;
            end
          end
        end
        S_TX_ACK: begin
          // cnt==1 marks that the master's ACK has been seen on this bit
          if (scl_rise) begin
            if (sda_s) state_next = S_WAIT_STOP;
            else       cnt_next   = CNT_ONE;
          end else if (scl_fall && cnt == CNT_ONE) begin
            tx_shift_next = {tx_data[DATA_LEN-2:0], 1'b0};
            tx_load_next  = 1'b1;
            drive_next    = ~tx_data[DATA_LEN-1];
            cnt_next      = CNT_ONE;
            state_next    = S_TX_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      drive_low  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_load    <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      drive_low  <= drive_next;
      rx_data    <= rx_data_next;
      rx_valid   <= rx_valid_next;
      tx_load    <= tx_load_next;
      addr_match <= addr_match_next;
      busy       <= busy_next;
    end
  end

  // Datapath shifters: contents are irrelevant until a byte is framed
  always_ff @(posedge clk) begin
    shift    <= shift_next;
    tx_shift <= tx_shift_next;
    rw       <= rw_next;
  end

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_fsm
//   Bus-level bench for i2c_slave_fsm. A behavioural I2C master drives scl and
//   an open-drain sda with a pull-up. Expected results come from transaction
//   level rules: own address ACKed, write bytes delivered, and read bytes
//   shifted out MSB first.
// ---------------------------------------------------------------------------
module tb_i2c_slave_fsm;

  localparam logic [6:0] OWN = 7'b1010110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic       tx_load, rx_valid, addr_match, busy;
  logic [7:0] rx_data;
  logic [3:0] state_slave;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl         (scl),
    .sda         (sda),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .addr_match  (addr_match),
    .busy        (busy),
    .state_slave (state_slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rxv_cnt = 0;
  int txl_cnt = 0;
  int am_cnt  = 0;

  always @(negedge clk) begin
    if (rx_valid)   rxv_cnt++;
    if (tx_load)    txl_cnt++;
    if (addr_match) am_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      wait_clk(4); m_low = 1'b0;
      wait_clk(4); scl = 1'b1;
      wait_clk(4);
    end else begin
      m_low = 1'b0;
      wait_clk(4);
    end
    m_low = 1'b1;
    wait_clk(4); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(4); m_low = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); m_low = 1'b0;
    wait_clk(8);
  endtask

  task automatic bit_cycle(input logic b_out, output logic seen);
    wait_clk(4); m_low = ~b_out;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); seen = sda;
    wait_clk(4); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    tx_data = next_tx;
    bit_cycle(nack, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(2);
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rst_sda: got %b expected 1", sda); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_tests++; if (state_slave !== 4'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state_slave); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
    rst_n = 1'b1;
    wait_clk(4);
    n_tests++; if ({sda, busy, state_slave, rx_data, rx_valid, tx_load, addr_match} !== {1'b1, 1'b0, 4'd0, 8'h00, 3'b000})
      begin n_fail++; $display("FAIL post_rst_outputs: got sda=%b busy=%b st=%0d rx=%h pulses=%b%b%b expected idle",
                               sda, busy, state_slave, rx_data, rx_valid, tx_load, addr_match); end
  endtask

  task automatic test_write();
    logic ack;
    int am0, rx0;
    am0 = am_cnt; rx0 = rxv_cnt;
    bus_start();
    wait_clk(2);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", busy); end
    n_tests++; if (state_slave !== 4'd1) begin n_fail++; $display("FAIL wr_state_addr: got %0d expected 1", state_slave); end
    send_byte({OWN, 1'b0}, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b expected 0", ack); end
    n_tests++; if (am_cnt - am0 !== 1) begin n_fail++; $display("FAIL wr_addr_match_pulses: got %0d expected 1", am_cnt - am0); end
    send_byte(8'hB9, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack: got %b expected 0", ack); end
    n_tests++; if (rx_data !== 8'hB9) begin n_fail++; $display("FAIL wr_rx_data: got %h expected b9", rx_data); end
    n_tests++; if (rxv_cnt - rx0 !== 1) begin n_fail++; $display("FAIL wr_rx_valid_pulses: got %0d expected 1", rxv_cnt - rx0); end
    bus_stop();
    n_tests++; if (state_slave !== 4'd0) begin n_fail++; $display("FAIL wr_stop_state: got %0d expected 0", state_slave); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_stop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_bad_addr();
    logic ack;
    int am0, rx0;
    am0 = am_cnt; rx0 = rxv_cnt;
    bus_start();
    send_byte({7'b1010111, 1'b0}, ack);
    n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL bad_addr_ack: got %b expected 1", ack); end
    n_tests++; if (state_slave !== 4'd7) begin n_fail++; $display("FAIL bad_addr_state: got %0d expected 7", state_slave); end
    send_byte(8'h55, ack);
    n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL bad_addr_data_ack: got %b expected 1", ack); end
    n_tests++; if (rxv_cnt - rx0 !== 0 || am_cnt - am0 !== 0)
      begin n_fail++; $display("FAIL bad_addr_pulses: got rxv=%0d am=%0d expected 0 0", rxv_cnt - rx0, am_cnt - am0); end
    bus_stop();
    n_tests++; if (state_slave !== 4'd0) begin n_fail++; $display("FAIL bad_addr_stop_state: got %0d expected 0", state_slave); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] b;
    int tl0;
    tl0 = txl_cnt;
    tx_data = 8'h8B;
    bus_start();
    send_byte({OWN, 1'b1}, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b expected 0", ack); end
    recv_byte(1'b0, 8'h3C, b);
    n_tests++; if (b !== 8'h8B) begin n_fail++; $display("FAIL rd_byte0: got %h expected 8b", b); end
    recv_byte(1'b1, 8'hA5, b);
    n_tests++; if (b !== 8'h3C) begin n_fail++; $display("FAIL rd_byte1: got %h expected 3c", b); end
    wait_clk(4);
    n_tests++; if (txl_cnt - tl0 !== 2) begin n_fail++; $display("FAIL rd_tx_load_pulses: got %0d expected 2", txl_cnt - tl0); end
    n_tests++; if (state_slave !== 4'd7) begin n_fail++; $display("FAIL rd_nack_state: got %0d expected 7", state_slave); end
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rd_nack_sda: got %b expected 1 (released)", sda); end
    bus_stop();
  endtask

  task automatic test_repeated_start();
    logic ack, s;
    logic [7:0] d;
    int rx0;
    rx0 = rxv_cnt;
    d = 8'($urandom);
    bus_start();
    send_byte({OWN, 1'b0}, ack);
    for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), s);
    bus_start();
    wait_clk(2);
    n_tests++; if (state_slave !== 4'd1) begin n_fail++; $display("FAIL rs_state: got %0d expected 1", state_slave); end
    n_tests++; if (rxv_cnt - rx0 !== 0) begin n_fail++; $display("FAIL rs_partial_rx_valid: got %0d expected 0", rxv_cnt - rx0); end
    send_byte({OWN, 1'b0}, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_addr_ack: got %b expected 0", ack); end
    send_byte(d, ack);
    n_tests++; if (rx_data !== d || rxv_cnt - rx0 !== 1)
      begin n_fail++; $display("FAIL rs_rx: got %h/%0d expected %h/1", rx_data, rxv_cnt - rx0, d); end
    bus_stop();
  endtask

  task automatic test_reset_mid_ack();
    logic ack, s;
    logic [7:0] a, d;
    a = {OWN, 1'b0};
    d = 8'($urandom);
    bus_start();
    for (int i = 7; i >= 0; i--) bit_cycle(a[i], s);
    wait_clk(4); m_low = 1'b0;
    wait_clk(4); scl = 1'b1;
    wait_clk(2);
    n_tests++; if (sda !== 1'b0) begin n_fail++; $display("FAIL mid_ack_driving: got %b expected 0", sda); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL mid_ack_rst_sda: got %b expected 1", sda); end
    n_tests++; if (state_slave !== 4'd0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL mid_ack_rst_state: got st=%0d busy=%b expected 0 0", state_slave, busy); end
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    bus_start();
    send_byte({OWN, 1'b0}, ack);
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL post_rst_addr_ack: got %b expected 0", ack); end
    send_byte(d, ack);
    n_tests++; if (rx_data !== d) begin n_fail++; $display("FAIL post_rst_rx_data: got %h expected %h", rx_data, d); end
    bus_stop();
  endtask

  // Random transactions against transaction-level expectations
  task automatic test_random();
    logic ack;
    logic [6:0] addr;
    logic rw, matched;
    logic [7:0] q[3];
    logic [7:0] b, exp_b;
    int n, rx0, tl0, am0;
    for (int t = 0; t < 8; t++) begin
      addr = 7'($urandom);
      if ($urandom_range(0, 1) == 1) addr = OWN;
      else if (addr == OWN) addr = addr ^ 7'h01;
      matched = (addr == OWN);
      rw = 1'($urandom);
      n = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) q[k] = 8'($urandom);
      rx0 = rxv_cnt; tl0 = txl_cnt; am0 = am_cnt;
      tx_data = q[0];
      bus_start();
      send_byte({addr, rw}, ack);
      n_tests++; if (ack !== !matched) begin n_fail++; $display("FAIL rnd_addr_ack t%0d: got %b expected %b", t, ack, !matched); end
      for (int k = 0; k < n; k++) begin
        if (!rw) begin
          send_byte(q[k], ack);
          n_tests++; if (ack !== !matched) begin n_fail++; $display("FAIL rnd_wr_ack t%0d: got %b expected %b", t, ack, !matched); end
          if (matched) begin
            n_tests++; if (rx_data !== q[k]) begin n_fail++; $display("FAIL rnd_rx_data t%0d: got %h expected %h", t, rx_data, q[k]); end
          end
        end else begin
          recv_byte((k == n - 1), (k < 2) ? q[k+1] : 8'($urandom), b);
          exp_b = matched ? q[k] : 8'hFF;
          n_tests++; if (b !== exp_b) begin n_fail++; $display("FAIL rnd_rd_byte t%0d: got %h expected %h", t, b, exp_b); end
        end
      end
      wait_clk(4);
      n_tests++; if (state_slave !== (!matched ? 4'd7 : (rw ? 4'd7 : 4'd3)))
        begin n_fail++; $display("FAIL rnd_state t%0d: got %0d", t, state_slave); end
      n_tests++; if (rxv_cnt - rx0 !== ((matched && !rw) ? n : 0) || txl_cnt - tl0 !== ((matched && rw) ? n : 0)
                     || am_cnt - am0 !== (matched ? 1 : 0))
        begin n_fail++; $display("FAIL rnd_pulses t%0d: got rxv=%0d txl=%0d am=%0d", t, rxv_cnt - rx0, txl_cnt - tl0, am_cnt - am0); end
      bus_stop();
      n_tests++; if (state_slave !== 4'd0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL rnd_stop t%0d: got st=%0d busy=%b expected 0 0", t, state_slave, busy); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_bad_addr();
    test_read();
    test_repeated_start();
    test_reset_mid_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
